// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port Mem arbiter: FSM states, port-id
// width and default bus widths. No logic, zero latency, no backpressure.
package mem_port_arbiter_pkg;

  localparam int NUM_PORTS          = 2;
  localparam int PORT_ID_W          = 1;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDR_WIDTH     = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  typedef logic [PORT_ID_W-1:0] port_id_t;

  // Grants are one-hot over two ports, so bit 1 alone identifies the winner.
  function automatic port_id_t grant_to_port(input logic [NUM_PORTS-1:0] grant);
    return port_id_t'(grant[1]);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Combinational one-hot grant for two request ports, zero latency; grants nothing
// unless idle. MEM_PORT_ARBITER_RR_EN: ties go to the port not granted last, else port 0.
module mem_port_arbiter_grant
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req_vld,
  input  port_id_t             i_ptr,
  input  logic                 i_idle,
  output logic [NUM_PORTS-1:0] o_grant
);

  logic [NUM_PORTS-1:0] w_tie_pick;

`ifdef MEM_PORT_ARBITER_RR_EN
  // i_ptr holds the last granted port; the other one wins the tie.
  assign w_tie_pick = (i_ptr == port_id_t'(1)) ? 2'b01 : 2'b10;
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;
  assign w_tie_pick   = 2'b01;
`endif

  always_comb begin
    o_grant = '0;
    if (i_idle) begin
      case (i_req_vld)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = w_tie_pick;
        default: o_grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter onto one Mem BEL: write completes 2 cycles after accept, read 3;
// req_ready only while idle. MEM_PORT_ARBITER_RR_EN selects round-robin over fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  UserCLK,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_reset
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_we;
  port_id_t                r_port;
  logic [1:0]              r_rsp_vld;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic                    w_idle;
  logic [NUM_PORTS-1:0]    w_grant;
  port_id_t                w_ptr;
  port_id_t                w_acc_port;
  logic                    w_accept;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic                    w_sel_we;
  logic [1:0]              w_rsp_nxt;
  logic                    w_wr_en;

  assign w_idle = (r_state == ST_IDLE);

  mem_port_arbiter_grant u_grant (
    .i_req_vld (req_valid),
    .i_ptr     (w_ptr),
    .i_idle    (w_idle),
    .o_grant   (w_grant)
  );

  // Ready is withheld during the reset cycle so nothing is accepted into a state being cleared.
  assign req_ready  = reset ? 2'b00 : w_grant;
  assign w_accept   = |(req_valid & req_ready);
  assign w_acc_port = grant_to_port(w_grant);

  assign w_sel_addr  = (w_acc_port == port_id_t'(1)) ? req_addr1  : req_addr0;
  assign w_sel_wdata = (w_acc_port == port_id_t'(1)) ? req_wdata1 : req_wdata0;
  assign w_sel_we    = (w_acc_port == port_id_t'(1)) ? req_we[1]  : req_we[0];

`ifdef MEM_PORT_ARBITER_RR_EN
  port_id_t r_last_port;

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_last_port <= port_id_t'(1);
    end else if (w_accept) begin
      r_last_port <= w_acc_port;
    end
  end

  assign w_ptr = r_last_port;
`else
  assign w_ptr = port_id_t'(1);
`endif

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_nxt   = 2'b00;
    w_wr_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_wr_en = r_we;
        if (r_we) begin
          w_state_nxt       = ST_IDLE;
          w_rsp_nxt[r_port] = 1'b1;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_state_nxt       = ST_IDLE;
        w_rsp_nxt[r_port] = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address and write data stay registered between accepts so Mem sees stable inputs.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_port    <= '0;
      r_rsp_vld <= 2'b00;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_we    <= w_sel_we;
        r_port  <= w_acc_port;
      end
      r_rsp_vld <= w_rsp_nxt;
      if (r_state == ST_CAPTURE) begin
        r_rdata <= mem_read_data;
      end
    end
  end

  assign mem_addr0      = r_addr;
  assign mem_write_data = r_wdata;
  assign mem_write_en   = w_wr_en & ~reset;
  assign mem_reset      = reset;
  assign rsp_valid      = r_rsp_vld;
  assign rsp_rdata      = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random requests on both ports checked against
// a transaction-timeline reference model and a behavioural Mem BEL.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef MEM_PORT_ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [1:0]    req_we = 2'b00;
  logic [AW-1:0] req_addr0 = '0, req_addr1 = '0;
  logic [DW-1:0] req_wdata0 = '0, req_wdata1 = '0;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_en;
  logic [DW-1:0] mem_read_data = '0;
  logic          mem_reset;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .UserCLK        (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr0      (req_addr0),
    .req_addr1      (req_addr1),
    .req_wdata0     (req_wdata0),
    .req_wdata1     (req_wdata1),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .mem_reset      (mem_reset)
  );

  // Mem BEL: synchronous write, read data one cycle after the address.
  logic [DW-1:0] bel [256];
  always_ff @(posedge clk) begin
    if (mem_write_en) bel[mem_addr0[7:0]] <= mem_write_data;
    mem_read_data <= bel[mem_addr0[7:0]];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  // Timeline slot: what the arbiter must show k cycles from now.
  typedef struct {
    bit            iss;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    rsp;
    bit            rd;
    logic [DW-1:0] rdata;
  } slot_t;

  txn_t          q0[$], q1[$];
  bit            pres[2];
  bit            rnd_mode = 1'b0;
  logic          rst_drv = 1'b1;
  slot_t         sl[4];
  int            busy;
  int            last_port;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [DW-1:0] ref_mem [256];
  int            grants_q[$];
  int            rsp_seen;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic txn_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic int qsize(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 4; k++) sl[k] = '{default: '0};
    busy = 0;
    last_port = 1;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
  endfunction

  function automatic int pending();
    int n;
    n = q0.size() + q1.size() + busy;
    for (int k = 0; k < 4; k++) n += int'(sl[k].iss) + int'(sl[k].rsp != 2'b00);
    return n;
  endfunction

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (!pres[p] && qsize(p) > 0 && (!rnd_mode || $urandom_range(3) != 0)) pres[p] = 1'b1;
      else if (pres[p] && rnd_mode && $urandom_range(19) == 0) pres[p] = 1'b0;
    end
    reset     = rst_drv;
    req_valid = {pres[1], pres[0]};
    if (pres[0]) begin req_we[0] = q0[0].we; req_addr0 = q0[0].addr; req_wdata0 = q0[0].data; end
    else begin req_we[0] = 1'($urandom); req_addr0 = $urandom; req_wdata0 = $urandom; end
    if (pres[1]) begin req_we[1] = q1[0].we; req_addr1 = q1[0].addr; req_wdata1 = q1[0].data; end
    else begin req_we[1] = 1'($urandom); req_addr1 = $urandom; req_wdata1 = $urandom; end
  endtask

  task automatic model_check();
    logic       rst;
    int         win;
    logic [1:0] e_rdy;
    bit         e_wen;
    txn_t       t;
    rst = reset;
    win = -1;
    e_rdy = 2'b00;
    if (!rst && busy == 0) begin
      case (req_valid)
        2'b01: win = 0;
        2'b10: win = 1;
        2'b11: win = RR_EN ? ((last_port == 1) ? 0 : 1) : 0;
        default: win = -1;
      endcase
    end
    if (win >= 0) e_rdy[win] = 1'b1;
    check_eq("req_ready", req_ready, e_rdy);
    check_eq("mem_reset", mem_reset, rst);
    if (sl[0].iss) begin e_addr = sl[0].addr; e_wdata = sl[0].wdata; end
    e_wen = sl[0].iss && sl[0].we && !rst;
    check_eq("mem_write_en", mem_write_en, e_wen);
    check_eq("mem_addr0", mem_addr0, e_addr);
    check_eq("mem_write_data", mem_write_data, e_wdata);
    if (e_wen) ref_mem[e_addr[7:0]] = e_wdata;
    if (sl[0].rd) e_rdata = sl[0].rdata;
    check_eq("rsp_valid", rsp_valid, sl[0].rsp);
    check_eq("rsp_rdata", rsp_rdata, e_rdata);
    if (rsp_valid != 2'b00) rsp_seen++;
    if (win >= 0) begin
      t = (win == 0) ? q0[0] : q1[0];
      grants_q.push_back(win);
      sl[1].iss = 1'b1; sl[1].we = t.we; sl[1].addr = t.addr; sl[1].wdata = t.data;
      if (t.we) begin
        sl[2].rsp[win] = 1'b1;
        busy = 2;
      end else begin
        sl[3].rsp[win] = 1'b1;
        sl[3].rd = 1'b1;
        sl[3].rdata = ref_mem[t.addr[7:0]];
        busy = 3;
      end
      last_port = win;
      if (win == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      pres[win] = 1'b0;
    end
    if (rst) clear_model();
    else begin
      for (int k = 0; k < 3; k++) sl[k] = sl[k+1];
      sl[3] = '{default: '0};
      if (busy > 0) busy--;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model_check();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (pending() != 0 && k < budget) begin
      step();
      k++;
    end
    check_eq("drain_done", pending(), 0);
  endtask

  task automatic do_reset(input int n);
    rst_drv = 1'b1;
    repeat (n) step();
    rst_drv = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 256; i++) begin bel[i] = '0; ref_mem[i] = '0; end
    clear_model();
    pres[0] = 1'b0; pres[1] = 1'b0;

    do_reset(2);

    // Write then read back on port 0.
    q0.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
    q0.push_back(mk(1'b0, 32'h10, 32'h0));
    drain(40);
    check_eq("p1_rdata", rsp_rdata, 32'hDEADBEEF);

    // Both ports reading 0x4/0x8 together from the first cycle out of reset.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 32'h4, $urandom));
      q1.push_back(mk(1'b0, 32'h8, $urandom));
    end
    do_reset(2);
    grants_q.delete();
    drain(100);
    check_eq("p2_ngrant", grants_q.size(), 8);
    for (int i = 0; i < grants_q.size() && i < 8; i++)
      check_eq($sformatf("p2_grant%0d", i), grants_q[i], RR_EN ? (i % 2) : ((i < 4) ? 0 : 1));

    // Reset lands in the ISSUE cycle of a write.
    q0.push_back(mk(1'b1, 32'h20, 32'h11111111));
    drain(40);
    q0.push_back(mk(1'b1, 32'h20, 32'h22222222));
    grants_q.delete();
    k = 0;
    while (grants_q.size() == 0 && k < 20) begin step(); k++; end
    check_eq("p3_accepted", grants_q.size(), 1);
    rst_drv = 1'b1;
    step();
    check_eq("p3_wen_in_reset", mem_write_en, 1'b0);
    rst_drv = 1'b0;
    rsp_seen = 0;
    repeat (4) step();
    check_eq("p3_no_rsp", rsp_seen, 0);
    q1.push_back(mk(1'b0, 32'h20, 32'h0));
    drain(40);
    check_eq("p3_old_data", rsp_rdata, 32'h11111111);

    // Port 1 stalls behind a port 0 read.
    q0.push_back(mk(1'b0, 32'h4, 32'h0));
    step();
    q1.push_back(mk(1'b1, 32'h30, 32'hCAFEF00D));
    drain(40);
    q1.push_back(mk(1'b0, 32'h30, 32'h0));
    drain(40);
    check_eq("p5_rdata", rsp_rdata, 32'hCAFEF00D);

    // Random traffic with gaps, early drops and occasional resets.
    rnd_mode = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (q0.size() < 3 && $urandom_range(2) == 0)
        q0.push_back(mk(1'($urandom), 32'($urandom_range(15)) << 2, $urandom));
      if (q1.size() < 3 && $urandom_range(2) == 0)
        q1.push_back(mk(1'($urandom), 32'($urandom_range(15)) << 2, $urandom));
      rst_drv = ($urandom_range(99) == 0);
      step();
    end
    rst_drv = 1'b0;
    drain(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of the data words and of the Mem read/write data.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of the request addresses and of the Mem addr0 port.
REQ-003 Clocking and reset SHALL be one clock and a synchronous, active-high reset.
REQ-004 UserCLK  in  1  SHALL be the single clock; every flop samples on its rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req_valid[1:0]  in  2  SHALL be the per-port request valid.
REQ-007 req_ready[1:0]  out  2  SHALL be the per-port request accept.
REQ-008 req_we[1:0]  in  2  SHALL select the operation per port: 1 = write, 0 = read.
REQ-009 req_addr0/req_addr1  in  ADDR_WIDTH each  SHALL be the per-port address.
REQ-010 req_wdata0/req_wdata1  in  DATA_WIDTH each  SHALL be the per-port write data.
REQ-011 rsp_valid[1:0]  out  2  SHALL be the per-port completion pulse, one cycle wide, for both reads and writes.
REQ-012 rsp_rdata  out  DATA_WIDTH  SHALL be the read data, valid only while the matching rsp_valid bit is 1.
REQ-013 mem_addr0 / mem_write_data / mem_write_en  out  ADDR_WIDTH / DATA_WIDTH / 1  SHALL drive the Mem BEL.
REQ-014 mem_read_data  in  DATA_WIDTH  SHALL carry Mem read data, valid one cycle after mem_addr0 is presented.
REQ-015 mem_reset  out  1  SHALL equal reset combinationally.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE and CAPTURE, encoded in 2 bits.
REQ-017 req_ready SHALL be nonzero only in IDLE, and SHALL be one-hot on the granted port.
- A request is accepted in the cycle where req_valid[p] and req_ready[p] are both 1.
REQ-018 On acceptance in cycle N, the FSM SHALL move to ISSUE and register addr, wdata, we and the port id.
REQ-019 In ISSUE (cycle N+1), mem_addr0 and mem_write_data SHALL present the latched values from registers.
- mem_write_en SHALL be 1 for exactly this cycle on a write and 0 otherwise.
REQ-020 Write completion: ISSUE SHALL go to IDLE, with rsp_valid[p] = 1 in cycle N+2.
- Write throughput is one operation per 2 cycles.
REQ-021 Read completion: ISSUE SHALL go to CAPTURE.
- CAPTURE (N+2) SHALL register mem_read_data into rsp_rdata.
- CAPTURE SHALL then go to IDLE, with rsp_valid[p] = 1 in cycle N+3.
REQ-022 Outside ISSUE, mem_write_en SHALL be 0, and mem_addr0/mem_write_data SHALL hold their last values.
REQ-023 When both ports are valid in IDLE, exactly one port SHALL be granted, per REQ-030/031.
- The other port's ready stays 0, and its request SHALL be held unchanged by the requester.
REQ-024 A requester dropping valid before acceptance SHALL cause no Mem access.
REQ-025 rsp_valid SHALL never assert for both ports in the same cycle.
REQ-026 rsp_rdata SHALL hold its value until the next read capture.

Reset
REQ-027 When reset is high at a clock edge, the following SHALL be forced regardless of state, including mid-ISSUE or mid-CAPTURE:
- state = IDLE, req_ready = 0 for that cycle, rsp_valid = 0, mem_write_en = 0;
- mem_addr0, mem_write_data and rsp_rdata = 0;
- RR pointer = port 1, so port 0 wins first.
REQ-028 An operation interrupted by reset SHALL produce no rsp_valid after reset deasserts.
REQ-029 The first accept after reset SHALL be possible in the first cycle with reset low.

Configuration
REQ-030 With MEM_PORT_ARBITER_RR_EN defined, arbitration SHALL be round-robin.
- On a tie, the grant goes to the port not granted last; the pointer updates on every acceptance.
REQ-031 Without MEM_PORT_ARBITER_RR_EN, arbitration SHALL be fixed priority: port 0 always wins a tie, and no pointer register exists.

Structure
REQ-032 Package mem_port_arbiter_pkg SHALL hold:
- the FSM state typedef;
- port-id width and number-of-ports (2) constants;
- the default DATA_WIDTH/ADDR_WIDTH values.
REQ-033 Grant selection SHALL live in one sub-module, mem_port_arbiter_grant.
- It SHALL be combinational, taking req_valid, the pointer and an idle flag, and returning a one-hot grant.
- The RR pointer SHALL be held in the parent.

Verification
REQ-034 Write then read, port 0: write addr 0x10, data 0xDEADBEEF, at cycle N.
- Required: mem_write_en = 1 at N+1 and rsp_valid[0] at N+2.
- A following read of 0x10 SHALL return rsp_rdata = 0xDEADBEEF, 3 cycles after its accept.
REQ-035 Simultaneous requests, both ports valid on reads of 0x4 and 0x8, macro undefined.
- Required: port 0 granted first, port 1 granted in the first IDLE after port 0 completes.
REQ-036 Same stimulus as REQ-035 held for 4 transactions per port, with MEM_PORT_ARBITER_RR_EN defined.
- Required: grants alternate 0,1,0,1...
REQ-037 Reset asserted in the ISSUE cycle of a write.
- Required: mem_write_en = 0 at that edge, no rsp_valid afterwards, and state = IDLE.
REQ-038 Stalled requester: port 1 valid while port 0 holds a read.
- Required: req_ready[1] = 0 until IDLE, port 1 addr/data sampled unchanged, and at most one rsp_valid bit high per cycle.
